// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cache-line <-> memory-burst adapter.
// Package name mutative_types is what the adapter and its interface import.
package mutative_types;
  localparam int CACHELINE_SIZE  = 256;
  localparam int BURST_WIDTH_DEF = 64;
  localparam int BURST_LEN       = CACHELINE_SIZE / BURST_WIDTH_DEF;
  localparam int OFFSET_BITS     = $clog2(CACHELINE_SIZE / 8);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BURST = 3'd1,
    ST_RD_REQ   = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4
  } adapter_state_e;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cacheline_adapter_if.sv
// Cache-side (dfp_*) and memory-side (bmem_*) signals of the adapter.
// slave = the adapter itself, master = the surrounding cache and memory.
interface cacheline_adapter_if #(
  parameter int BURST_WIDTH = mutative_types::BURST_WIDTH_DEF
);
  logic [31:0]                               dfp_addr;
  logic                                      dfp_read;
  logic                                      dfp_write;
  logic [mutative_types::CACHELINE_SIZE-1:0] dfp_wdata;
  logic [mutative_types::CACHELINE_SIZE-1:0] dfp_rdata;
  logic                                      dfp_resp;
  logic [31:0]                               bmem_addr;
  logic                                      bmem_read;
  logic                                      bmem_write;
  logic [BURST_WIDTH-1:0]                    bmem_wdata;
  logic                                      bmem_ready;
  logic [BURST_WIDTH-1:0]                    bmem_rdata;
  logic                                      bmem_rvalid;
  logic [31:0]                               bmem_raddr;
  logic                                      adapter_err;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid, bmem_raddr,
    output dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output adapter_err
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid, bmem_raddr,
    input  dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  adapter_err
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits cache-line writebacks into memory beats and assembles read beats into lines.
// ADAPTER_ADDR_CHECK_EN: drop read beats whose bmem_raddr mismatches, flag adapter_err.
//   state    | meaning
//   IDLE     | wait for dfp_write (priority) or dfp_read
//   WR_BURST | drive write beats, advance on bmem_ready
//   RD_REQ   | hold bmem_read until accepted
//   RD_WAIT  | collect rvalid beats into the fill line
//   RESP     | one-cycle dfp_resp
module cacheline_adapter
  import mutative_types::*;
#(
  parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);
  localparam int N_BEATS = CACHELINE_SIZE / BURST_WIDTH;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  adapter_state_e            state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [31:0]               addr_q, addr_d;
  logic [CACHELINE_SIZE-1:0] wline_q, wline_d;
  logic [CACHELINE_SIZE-1:0] rline_q, rline_d;
  logic                      beat_ok;
  logic                      bmem_read, bmem_write, dfp_resp;
  logic [31:0]               bmem_addr;
  logic [BURST_WIDTH-1:0]    bmem_wdata;
`ifdef ADAPTER_ADDR_CHECK_EN
  logic                      err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    wline_d    = wline_q;
    rline_d    = rline_q;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
`ifdef ADAPTER_ADDR_CHECK_EN
    err_d      = err_q;
    beat_ok    = (bus.bmem_raddr == addr_q);
`else
    beat_ok    = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (bus.dfp_write) begin
          addr_d  = line_align(bus.dfp_addr);
          wline_d = bus.dfp_wdata;
          state_d = ST_WR_BURST;
        end else if (bus.dfp_read) begin
          addr_d  = line_align(bus.dfp_addr);
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wline_q[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH];
        if (bus.bmem_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = ST_RESP;
        end
      end
      ST_RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bus.bmem_ready) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.bmem_rvalid) begin
          if (beat_ok) begin
            rline_d[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH] = bus.bmem_rdata;
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) state_d = ST_RESP;
          end else begin
`ifdef ADAPTER_ADDR_CHECK_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      ST_RESP: begin
        dfp_resp = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

`ifdef ADAPTER_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign bus.adapter_err = err_q;
`else
  assign bus.adapter_err = 1'b0;
`endif

  assign bus.dfp_rdata  = rline_q;
  assign bus.dfp_resp   = dfp_resp;
  assign bus.bmem_addr  = bmem_addr;
  assign bus.bmem_read  = bmem_read;
  assign bus.bmem_write = bmem_write;
  assign bus.bmem_wdata = bmem_wdata;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed + randomized bench for cacheline_adapter; reference line built from beat lists.
// Honours ADAPTER_ADDR_CHECK_EN when the same macro is given to the bench.
module tb_cacheline_adapter;
  import mutative_types::*;
  localparam int BW = 64;
`ifdef ADAPTER_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   exp_err  = 1'b0;
  logic [63:0] it_d[$];
  logic [31:0] it_a[$];

  cacheline_adapter_if #(.BURST_WIDTH(BW)) bus ();
  cacheline_adapter #(.BURST_WIDTH(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input int mode, input bit also_read);
    logic [31:0] la;
    int k, cyc, stall_left;
    bit r, resp_seen, rd_seen;
    la = addr & 32'hFFFF_FFE0;
    bus.dfp_addr  = addr;
    bus.dfp_wdata = line;
    bus.dfp_write = 1'b1;
    bus.dfp_read  = also_read;
    k = 0; cyc = 0; resp_seen = 0; rd_seen = 0;
    stall_left = (mode == 1) ? 3 : 0;
    while (!resp_seen && cyc < 100) begin
      if (mode == 2) r = 1'($urandom_range(0, 1));
      else if (bus.bmem_write && k == 1 && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else r = 1'b1;
      bus.bmem_ready = r;
      if (bus.bmem_write) begin
        chk("wr_addr", bus.bmem_addr, la);
        chk("wr_beat", bus.bmem_wdata, 64'(line >> (64 * k)));
        if (r) k++;
      end
      tick();
      cyc++;
      if (bus.bmem_read) rd_seen = 1'b1;
      resp_seen = bus.dfp_resp;
    end
    chk("wr_resp", resp_seen, 1);
    chk("wr_beats", k, 4);
    if (mode == 0) chk("wr_latency", cyc, 5);
    chk("wr_no_read", rd_seen, 0);
    bus.dfp_write  = 1'b0;
    bus.dfp_read   = 1'b0;
    bus.bmem_ready = 1'b0;
    tick();
    chk("wr_resp_pulse", bus.dfp_resp, 0);
    chk("wr_idle_write", bus.bmem_write, 0);
    chk("wr_idle_addr", bus.bmem_addr, 0);
  endtask

  // Reference: the first four beats that pass the address rule fill slices 0..3.
  task automatic do_read(input logic [31:0] addr, input int gap_max, input int abort_after);
    logic [31:0]  la;
    logic [255:0] exp_line;
    int acc, need, idx, cyc, gap;
    bit r, granted, resp_seen, addr_checked;
    la = addr & 32'hFFFF_FFE0;
    exp_line = '0; acc = 0; need = -1;
    for (int i = 0; i < it_d.size(); i++) begin
      if (need < 0) begin
        if (!CHECK_EN || it_a[i] == la) begin
          exp_line = exp_line | (256'(it_d[i]) << (64 * acc));
          acc++;
          if (acc == 4) need = i + 1;
        end else if (abort_after < 0) exp_err = 1'b1;
      end
    end
    bus.dfp_addr = addr;
    bus.dfp_read = 1'b1;
    granted = 0; cyc = 0; addr_checked = 0;
    while (!granted && cyc < 50) begin
      r = 1'($urandom_range(0, 1));
      bus.bmem_ready = r;
      if (bus.bmem_read) begin
        if (!addr_checked) begin
          chk("rd_addr", bus.bmem_addr, la);
          addr_checked = 1'b1;
        end
        granted = r;
      end
      tick();
      cyc++;
    end
    bus.bmem_ready = 1'b0;
    chk("rd_grant", granted, 1);
    if (!granted) begin
      bus.dfp_read = 1'b0;
      return;
    end
    chk("rd_req_drop", bus.bmem_read, 0);
    idx = 0; cyc = 0; resp_seen = 0;
    gap = int'($urandom_range(0, gap_max));
    while (!resp_seen && cyc < 200 && !(abort_after >= 0 && idx >= abort_after)) begin
      if (gap == 0 && idx < it_d.size()) begin
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = it_d[idx];
        bus.bmem_raddr  = it_a[idx];
        idx++;
        gap = int'($urandom_range(0, gap_max));
      end else begin
        bus.bmem_rvalid = 1'b0;
        if (gap > 0) gap--;
      end
      tick();
      cyc++;
      bus.bmem_rvalid = 1'b0;
      if (bus.dfp_resp) resp_seen = 1'b1;
    end
    if (abort_after >= 0) begin
      chk("abort_early_resp", resp_seen, 0);
      return;
    end
    chk("rd_resp", resp_seen, 1);
    chk("rd_beats_used", idx, need);
    chk("rd_line", bus.dfp_rdata, exp_line);
    chk("rd_err", bus.adapter_err, exp_err);
    bus.dfp_read = 1'b0;
    tick();
    chk("rd_resp_pulse", bus.dfp_resp, 0);
    chk("rd_idle_addr", bus.bmem_addr, 0);
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [31:0] a);
    it_d.push_back(d);
    it_a.push_back(a);
  endtask

  initial begin
    logic [255:0] line;
    logic [31:0]  addr;
    bit           resp_any;
    rst = 1'b1;
    bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0; bus.bmem_raddr = '0;
    repeat (3) tick();
    chk("rst_resp", bus.dfp_resp, 0);
    chk("rst_read", bus.bmem_read, 0);
    chk("rst_write", bus.bmem_write, 0);
    chk("rst_addr", bus.bmem_addr, 0);
    chk("rst_wdata", bus.bmem_wdata, 0);
    chk("rst_rdata", bus.dfp_rdata, 0);
    chk("rst_err", bus.adapter_err, 0);
    rst = 1'b0;
    tick();

    do_write(32'h0000_1234, {64'h4, 64'h3, 64'h2, 64'h1}, 0, 1'b0);

    it_d.delete(); it_a.delete();
    push_beat(64'hAAAA_0000_0000_000A, 32'h40);
    push_beat(64'hBBBB_0000_0000_000B, 32'h40);
    push_beat(64'hCCCC_0000_0000_000C, 32'h40);
    push_beat(64'hDDDD_0000_0000_000D, 32'h40);
    do_read(32'h0000_0040, 3, -1);
    chk("read_const_line", bus.dfp_rdata,
        {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
         64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A});

    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write(32'hABCD_0047, line, 1, 1'b0);

    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write(32'h0000_0300, line, 0, 1'b1);

    it_d.delete(); it_a.delete();
    for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, 32'h40);
    do_read(32'h0000_0040, 2, 2);
    bus.dfp_read = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    chk("midrst_read", bus.bmem_read, 0);
    chk("midrst_rdata", bus.dfp_rdata, 0);
    rst = 1'b0;
    exp_err = 1'b0;
    resp_any = 1'b0;
    repeat (4) begin
      tick();
      if (bus.dfp_resp) resp_any = 1'b1;
    end
    chk("midrst_no_resp", resp_any, 0);
    it_d.delete(); it_a.delete();
    for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, 32'h100);
    do_read(32'h0000_0100, 1, -1);

    it_d.delete(); it_a.delete();
    push_beat(64'h1111_1111_1111_1111, 32'h100);
    push_beat(64'hBAD0_BAD0_BAD0_BAD0, 32'h200);
    push_beat(64'h2222_2222_2222_2222, 32'h100);
    push_beat(64'h3333_3333_3333_3333, 32'h100);
    push_beat(64'h4444_4444_4444_4444, 32'h100);
    do_read(32'h0000_0100, 1, -1);
    chk("mismatch_err_flag", bus.adapter_err, CHECK_EN);

    for (int t = 0; t < 8; t++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(addr, line, 2, 1'($urandom_range(0, 1)));
      end else begin
        it_d.delete(); it_a.delete();
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 4) == 0)
            push_beat({$urandom, $urandom}, (addr & 32'hFFFF_FFE0) ^ 32'h0000_0400);
          push_beat({$urandom, $urandom}, addr & 32'hFFFF_FFE0);
        end
        do_read(addr, 2, -1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 Parameter BURST_WIDTH, default 64: memory beat width in bits; SHALL divide CACHELINE_SIZE (256).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 dfp_addr  input  32  cache-side line address; low OFFSET_BITS ignored.
REQ-005 dfp_read  input  1  line fill request, held until dfp_resp.
REQ-006 dfp_write  input  1  line writeback request, held until dfp_resp.
REQ-007 dfp_wdata  input  CACHELINE_SIZE  writeback line, held with dfp_write.
REQ-008 dfp_rdata  output  CACHELINE_SIZE  assembled fill line.
REQ-009 dfp_resp  output  1  one-cycle completion pulse.
REQ-010 bmem_addr  output  32  line-aligned memory address.
REQ-011 bmem_read  output  1  burst read request.
REQ-012 bmem_write  output  1  write beat valid.
REQ-013 bmem_wdata  output  BURST_WIDTH  current write beat.
REQ-014 bmem_ready  input  1  memory accepts request/beat this cycle.
REQ-015 bmem_rdata  input  BURST_WIDTH  read beat.
REQ-016 bmem_rvalid  input  1  read beat valid.
REQ-017 bmem_raddr  input  32  line address tagging the read beat.
REQ-018 adapter_err  output  1  sticky address-mismatch flag (see Configuration).

Function
REQ-019 FSM states: IDLE, WR_BURST, RD_REQ, RD_WAIT, RESP.
REQ-020 IDLE: dfp_write=1 -> capture {dfp_addr[31:5],5'b0} and dfp_wdata, go WR_BURST; else dfp_read=1 -> capture address, go RD_REQ; write wins if both high.
REQ-021 WR_BURST: bmem_write=1, bmem_wdata = captured line slice [beat*64 +: 64], beat counter (2 bits) advances only when bmem_ready=1; after beat 3 accepted -> RESP.
REQ-022 RD_REQ: bmem_read=1 held until sampled with bmem_ready=1 -> RD_WAIT; bmem_read deasserted from next cycle.
REQ-023 RD_WAIT: each bmem_rvalid beat written into dfp_rdata slice [beat*64 +: 64], counter increments; beat 3 -> RESP; beats arriving in any other state ignored.
REQ-024 RESP: dfp_resp=1 exactly one cycle, then IDLE; requests not sampled in RESP.
REQ-025 Min latency with bmem_ready=1: write 1(IDLE)+4+1 = dfp_resp in 6th cycle after request seen; read dfp_resp 1 cycle after last rvalid beat.
REQ-026 dfp_rdata holds last assembled line until overwritten by next read; bmem_addr valid only while bmem_read/bmem_write high, 0 otherwise.
REQ-027 Beat counter wraps 3->0 on burst completion; never indexes beyond slice 3.

Reset
REQ-028 rst=1 SHALL force IDLE, counter 0, dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0, adapter_err=0.
REQ-029 rst mid-burst SHALL abandon the burst, discard partial data, emit no dfp_resp.

Configuration
REQ-030 Macro ADAPTER_ADDR_CHECK_EN defined: in RD_WAIT, rvalid beat with bmem_raddr != captured address is discarded (counter unchanged) and sets adapter_err until rst.
REQ-031 Macro undefined: bmem_raddr unused, every rvalid beat in RD_WAIT accepted, adapter_err tied 0.

Structure
REQ-032 BURST_WIDTH default, BURST_LEN (CACHELINE_SIZE/BURST_WIDTH) and the adapter state enum SHALL live in mutative_types; address alignment uses OFFSET_BITS from it.
REQ-033 Single flat module; no sub-modules.

Verification
REQ-034 Write addr 0x0000_1234, line = {64'h4,64'h3,64'h2,64'h1}, ready=1 -> bmem_addr 0x0000_1220, beats 1,2,3,4 in consecutive cycles, dfp_resp next cycle.
REQ-035 Read 0x0000_0040, rvalid beats A,B,C,D with gaps -> dfp_rdata {D,C,B,A}, single dfp_resp pulse after D.
REQ-036 bmem_ready low 3 cycles during beat 2 of write -> beat 2 data and address held stable, total 4 accepted beats.
REQ-037 dfp_read and dfp_write both high in IDLE -> write burst only, bmem_read stays 0.
REQ-038 rst after 2 read beats, then new read 0x100 -> no dfp_resp for aborted read, new line correct.
REQ-039 ADAPTER_ADDR_CHECK_EN set, one beat with bmem_raddr 0x200 during read of 0x100 -> beat dropped, adapter_err=1, line completes from remaining 4 matching beats.
